ls_add_vec_sequencer: RTL and testbench
=======================================

// Module: ls_add_vec_sequencer
// PURPOSE
//   Sequences the load/store address-generation datapath (shift-left + add) over one vector.
//   Accepts one tagged base operand per vector and emits VEC_WIDTH tagged element addresses,
//   one per handshake: addr[i] = (base << cfg_ls) + cfg_add + i*cfg_stride.
//   Sits between the PE operand mux and the data-memory port.
//   Holds the shift/add/stride configuration registers and a vector element counter.
// PARAMETERS
//   DATA_WIDTH  8  address/data width; operands carry 1 extra MSB valid tag
//   VEC_WIDTH   4  elements per vector (>=2); VEC_WIDTH_BITS = $clog2(VEC_WIDTH)
// PORTS
//   clk           in   1              clock; all state updates on rising edge
//   rst           in   1              synchronous active-high reset
//   cfg_we        in   1              config write strobe; honoured only in IDLE
//   cfg_ls        in   DATA_WIDTH     shift amount
//   cfg_add       in   DATA_WIDTH     additive constant
//   cfg_stride    in   DATA_WIDTH     per-element address increment
//   in_valid      in   1              base operand offered
//   in_ready      out  1              base operand can be accepted
//   in_data       in   DATA_WIDTH+1   {tag, base}; tag = MSB
//   out_valid     out  1              element address valid
//   out_ready     in   1              consumer accepts element
//   out_data      out  DATA_WIDTH+1   {tag, address}
//   out_vec_idx   out  VEC_WIDTH_BITS index of current element
//   busy          out  1              high in ISSUE
//   done          out  1              1-cycle pulse after last element handshake
// BEHAVIOUR
//   Reset: state=IDLE; cfg regs, base, tag, idx = 0; in_ready=1, out_valid=0, out_data=0,
//     out_vec_idx=0, busy=0, done=0. Reset mid-ISSUE aborts vector; no further outputs.
//   States: IDLE, ISSUE.
//   IDLE: in_ready=1, out_valid=0. cfg_we loads cfg_ls/add/stride at edge.
//     in_valid&in_ready: latch base/tag, idx<=0, ->ISSUE. First out_valid the next cycle.
//     cfg_we and accept in same cycle: new cfg applies to this vector.
//   ISSUE: in_ready=0, busy=1, out_valid=1; cfg_we ignored (regs hold).
//     out_data/out_vec_idx combinational from registered state; stable while out_ready=0.
//     out_valid&out_ready: idx<=idx+1; if idx==VEC_WIDTH-1 -> IDLE, done=1 next cycle.
//   Throughput: one element/cycle at out_ready=1; vector = VEC_WIDTH cycles + 1 IDLE cycle
//     before next accept (no back-to-back overlap).
//   Arithmetic: all terms modulo 2^DATA_WIDTH; base<<cfg_ls with cfg_ls>=DATA_WIDTH -> 0;
//     i*cfg_stride truncated to DATA_WIDTH; sums wrap silently.
//   Tag: tag=1 -> out_data={1,addr}. tag=0 -> still emits VEC_WIDTH elements, out_data=0
//     (tag 0, addr 0) so downstream lockstep is preserved.
//   done: exactly one cycle, coincident with return to IDLE (in_ready=1 that cycle).
// TESTING (DATA_WIDTH=8, VEC_WIDTH=4)
//   T1 cfg ls=2,add=0x10,stride=1; in {1,0x03}, out_ready=1 -> out_data 0x11C,0x11D,0x11E,0x11F,
//      idx 0..3, done one cycle after 4th handshake.
//   T2 cfg ls=0,add=0x01,stride=0x80; in {1,0xFF} -> 0x100,0x180,0x100,0x180 (wrap).
//   T3 tag 0 input {0,0x55} -> four elements out_data=0x000, done asserted, in_ready low meanwhile.
//   T4 out_ready low 3 cycles at idx=1 -> out_data/out_vec_idx held; cfg_we during ISSUE has
//      no effect on remaining elements; next vector uses new cfg only if written in IDLE.
//   T5 cfg ls=9 -> all addresses = add + i*stride; rst asserted at idx=2 -> next cycle
//      out_valid=0, in_ready=1, cfg regs 0.
//   T6 random in_valid/out_ready stall stress vs reference model; element count and order exact.

Source files
------------

// File: rtl/ls_add_vec_sequencer_if.sv
// ============================================================================
// Module  : ls_add_vec_sequencer_if
// Brief   : Config, base-operand and element-address bundle for the sequencer
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ls_add_vec_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_WIDTH  = 4
);
   localparam int VEC_WIDTH_BITS = $clog2(VEC_WIDTH);

   logic                      cfg_we;
   logic [DATA_WIDTH-1:0]     cfg_ls;
   logic [DATA_WIDTH-1:0]     cfg_add;
   logic [DATA_WIDTH-1:0]     cfg_stride;
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH:0]       in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_WIDTH:0]       out_data;
   logic [VEC_WIDTH_BITS-1:0] out_vec_idx;
   logic                      busy;
   logic                      done;

   // master: upstream driver / downstream consumer side
   modport master (
      output cfg_we, cfg_ls, cfg_add, cfg_stride,
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_vec_idx, busy, done
   );

   // slave: the sequencer itself
   modport slave (
      input  cfg_we, cfg_ls, cfg_add, cfg_stride,
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_vec_idx, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/ls_add_vec_sequencer.sv
// ============================================================================
// Module  : ls_add_vec_sequencer
// Brief   : Expands one tagged base into VEC_WIDTH shift/add/stride addresses
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ls_add_vec_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_WIDTH  = 4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   ls_add_vec_sequencer_if.slave  bus
);
   localparam int VEC_WIDTH_BITS = $clog2(VEC_WIDTH);
   localparam logic [VEC_WIDTH_BITS-1:0] C_LAST_IDX = VEC_WIDTH_BITS'(VEC_WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                    state_q,      state_d;
   logic [VEC_WIDTH_BITS-1:0] idx_q,        idx_d;
   logic [DATA_WIDTH-1:0]     base_q,       base_d;
   logic                      tag_q,        tag_d;
   logic [DATA_WIDTH-1:0]     cfg_ls_q,     cfg_ls_d;
   logic [DATA_WIDTH-1:0]     cfg_add_q,    cfg_add_d;
   logic [DATA_WIDTH-1:0]     cfg_stride_q, cfg_stride_d;
   logic                      done_q,       done_d;

   logic [DATA_WIDTH-1:0]     w_shifted;
   logic [DATA_WIDTH-1:0]     w_offset;
   logic [DATA_WIDTH-1:0]     w_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         base_q       <= '0;
         tag_q        <= 1'b0;
         cfg_ls_q     <= '0;
         cfg_add_q    <= '0;
         cfg_stride_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         base_q       <= base_d;
         tag_q        <= tag_d;
         cfg_ls_q     <= cfg_ls_d;
         cfg_add_q    <= cfg_add_d;
         cfg_stride_q <= cfg_stride_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      base_d       = base_q;
      tag_d        = tag_q;
      cfg_ls_d     = cfg_ls_q;
      cfg_add_d    = cfg_add_q;
      cfg_stride_d = cfg_stride_q;
      done_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_we) begin
               cfg_ls_d     = bus.cfg_ls;
               cfg_add_d    = bus.cfg_add;
               cfg_stride_d = bus.cfg_stride;
            end
            if (bus.in_valid) begin
               base_d  = bus.in_data[DATA_WIDTH-1:0];
               tag_d   = bus.in_data[DATA_WIDTH];
               idx_d   = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (bus.out_ready) begin
               if (idx_q == C_LAST_IDX) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shifts of DATA_WIDTH or more clear the base; every term wraps at DATA_WIDTH.
   always_comb begin
      w_shifted = (32'(cfg_ls_q) >= 32'(DATA_WIDTH)) ? '0 : (base_q << cfg_ls_q);
      w_offset  = cfg_stride_q * DATA_WIDTH'(idx_q);
      w_addr    = w_shifted + cfg_add_q + w_offset;
   end

   assign bus.in_ready    = (state_q == ST_IDLE);
   assign bus.out_valid   = (state_q == ST_ISSUE);
   assign bus.busy        = (state_q == ST_ISSUE);
   assign bus.done        = done_q;
   assign bus.out_vec_idx = idx_q;
   // Untagged vectors still issue every slot, but as all-zero words.
   assign bus.out_data    = ((state_q == ST_ISSUE) && tag_q) ? {1'b1, w_addr} : '0;

endmodule

`default_nettype wire

// File: tb/tb_ls_add_vec_sequencer.sv
// ============================================================================
// Module  : tb_ls_add_vec_sequencer
// Brief   : Directed vectors plus randomised stall run for the sequencer
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ls_add_vec_sequencer;
   localparam int DATA_WIDTH = 8;
   localparam int VEC_WIDTH  = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   ls_add_vec_sequencer_if #(.DATA_WIDTH(DATA_WIDTH), .VEC_WIDTH(VEC_WIDTH)) bus ();

   ls_add_vec_sequencer #(.DATA_WIDTH(DATA_WIDTH), .VEC_WIDTH(VEC_WIDTH)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [7:0] ls, input logic [7:0] add, input logic [7:0] stride);
      bus.cfg_we     = 1'b1;
      bus.cfg_ls     = ls;
      bus.cfg_add    = add;
      bus.cfg_stride = stride;
      tick();
      bus.cfg_we     = 1'b0;
   endtask

   task automatic accept(input logic [8:0] din);
      check("idle_in_ready", 16'(bus.in_ready), 16'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = din;
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Drain one vector at full rate and check each element plus the done pulse.
   task automatic drain(input string tag, input logic [3:0][8:0] exp);
      bus.out_ready = 1'b1;
      for (int i = 0; i < VEC_WIDTH; i++) begin
         check({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
         check({tag, "_busy"},  16'(bus.busy), 16'd1);
         check({tag, "_inrdy"}, 16'(bus.in_ready), 16'd0);
         check({tag, "_data"},  16'(bus.out_data), 16'(exp[i]));
         check({tag, "_idx"},   16'(bus.out_vec_idx), 16'(i));
         check({tag, "_nodone"}, 16'(bus.done), 16'd0);
         tick();
      end
      check({tag, "_done"},      16'(bus.done), 16'd1);
      check({tag, "_done_rdy"},  16'(bus.in_ready), 16'd1);
      check({tag, "_done_vld"},  16'(bus.out_valid), 16'd0);
      tick();
      check({tag, "_done_clr"},  16'(bus.done), 16'd0);
   endtask

   function automatic logic [8:0] model_addr(input logic tag, input logic [7:0] base,
                                             input logic [7:0] ls, input logic [7:0] add,
                                             input logic [7:0] stride, input int i);
      logic [7:0] sh;
      logic [7:0] off;
      logic [7:0] a;
      if (!tag) return 9'h000;
      sh  = (ls >= 8) ? 8'h00 : 8'(base << ls);
      off = 8'(stride * 8'(i));
      a   = sh + add + off;
      return {1'b1, a};
   endfunction

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_ls     = '0;
      bus.cfg_add    = '0;
      bus.cfg_stride = '0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 16'(bus.in_ready), 16'd1);
      check("rst_out_valid", 16'(bus.out_valid), 16'd0);
      check("rst_out_data", 16'(bus.out_data), 16'd0);
      check("rst_idx", 16'(bus.out_vec_idx), 16'd0);
      check("rst_busy", 16'(bus.busy), 16'd0);
      check("rst_done", 16'(bus.done), 16'd0);
      rst = 1'b0;
      tick();

      // T1: basic shift/add/stride
      write_cfg(8'd2, 8'h10, 8'h01);
      accept({1'b1, 8'h03});
      drain("t1", {9'h11F, 9'h11E, 9'h11D, 9'h11C});

      // T2: additive wrap
      write_cfg(8'd0, 8'h01, 8'h80);
      accept({1'b1, 8'hFF});
      drain("t2", {9'h180, 9'h100, 9'h180, 9'h100});

      // T3: untagged base issues zero words
      accept({1'b0, 8'h55});
      drain("t3", {9'h000, 9'h000, 9'h000, 9'h000});

      // T4: stall at idx 1 with an ignored config write
      write_cfg(8'd1, 8'h20, 8'h04);
      accept({1'b1, 8'h10});
      bus.out_ready = 1'b1;
      check("t4_e0", 16'(bus.out_data), 16'h140);
      tick();
      bus.out_ready  = 1'b0;
      bus.cfg_we     = 1'b1;
      bus.cfg_ls     = 8'd0;
      bus.cfg_add    = 8'h00;
      bus.cfg_stride = 8'h10;
      for (int s = 0; s < 3; s++) begin
         check("t4_hold_data", 16'(bus.out_data), 16'h144);
         check("t4_hold_idx", 16'(bus.out_vec_idx), 16'd1);
         check("t4_hold_vld", 16'(bus.out_valid), 16'd1);
         tick();
      end
      bus.cfg_we    = 1'b0;
      bus.out_ready = 1'b1;
      check("t4_e1", 16'(bus.out_data), 16'h144);
      tick();
      check("t4_e2", 16'(bus.out_data), 16'h148);
      tick();
      check("t4_e3", 16'(bus.out_data), 16'h14C);
      tick();
      check("t4_done", 16'(bus.done), 16'd1);
      tick();
      accept({1'b1, 8'h10});
      drain("t4_old", {9'h14C, 9'h148, 9'h144, 9'h140});
      // config write in the same cycle as accept applies to that vector
      bus.cfg_we     = 1'b1;
      bus.cfg_ls     = 8'd0;
      bus.cfg_add    = 8'h00;
      bus.cfg_stride = 8'h10;
      accept({1'b1, 8'h10});
      bus.cfg_we     = 1'b0;
      drain("t4_new", {9'h140, 9'h130, 9'h120, 9'h110});

      // T5: oversize shift, then reset mid-vector
      write_cfg(8'd9, 8'h30, 8'h03);
      accept({1'b1, 8'hAB});
      bus.out_ready = 1'b1;
      check("t5_e0", 16'(bus.out_data), 16'h130);
      tick();
      check("t5_e1", 16'(bus.out_data), 16'h133);
      tick();
      check("t5_e2", 16'(bus.out_data), 16'h136);
      check("t5_idx2", 16'(bus.out_vec_idx), 16'd2);
      rst = 1'b1;
      tick();
      check("t5_rst_vld", 16'(bus.out_valid), 16'd0);
      check("t5_rst_rdy", 16'(bus.in_ready), 16'd1);
      check("t5_rst_data", 16'(bus.out_data), 16'd0);
      check("t5_rst_done", 16'(bus.done), 16'd0);
      rst = 1'b0;
      tick();
      check("t5_post_vld", 16'(bus.out_valid), 16'd0);
      // cleared config: address collapses to the base itself
      accept({1'b1, 8'h77});
      drain("t5_clr", {9'h177, 9'h177, 9'h177, 9'h177});

      // T6: randomised idle gaps and consumer stalls against the model
      for (int v = 0; v < 20; v++) begin
         logic [7:0] ls, add, stride, base;
         logic       tag;
         int         got_n;
         int         budget;
         ls     = 8'($urandom_range(0, 10));
         add    = 8'($urandom);
         stride = 8'($urandom);
         base   = 8'($urandom);
         tag    = ($urandom_range(0, 3) != 0);
         write_cfg(ls, add, stride);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         accept({tag, base});
         got_n  = 0;
         budget = 0;
         while (got_n < VEC_WIDTH && budget < 100) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            check("t6_valid", 16'(bus.out_valid), 16'd1);
            if (bus.out_ready) begin
               check("t6_data", 16'(bus.out_data), 16'(model_addr(tag, base, ls, add, stride, got_n)));
               check("t6_idx", 16'(bus.out_vec_idx), 16'(got_n));
               got_n++;
            end
            tick();
            budget++;
         end
         check("t6_count", 16'(got_n), 16'(VEC_WIDTH));
         check("t6_done", 16'(bus.done), 16'd1);
         check("t6_idle", 16'(bus.out_valid), 16'd0);
         bus.out_ready = 1'b0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
